// File: rtl/trng_rx.sv
// UART (8N1) receiver feeding a framed-payload parser with CRC-32C frame check.
// Frame: SOF 00 01 02 03, 128 payload bytes, 4 CRC bytes LSB first.
module trng_rx #(
  parameter int unsigned CYCLES_PER_BIT = 32
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_serial_data,
  output logic       o_serial_rts_n,
  output logic [7:0] o_dat,
  output logic       o_valid,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [7:0] o_err_cnt
);

  localparam int unsigned CW = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CW-1:0] BitLast  = CW'(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HalfLast = CW'((CYCLES_PER_BIT + 1) / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;
  typedef enum logic [1:0] {StHunt, StPayload, StCrc} parse_st_e;

  // Synchronizer resets low so a line already low at release never looks like an edge.
  logic sync1_q, line_q, line_prev_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q     <= 1'b0;
      line_q      <= 1'b0;
      line_prev_q <= 1'b0;
    end else begin
      sync1_q     <= i_serial_data;
      line_q      <= sync1_q;
      line_prev_q <= line_q;
    end
  end

  uart_st_e        uart_q;
  logic [CW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_byte_q;
  logic            rx_stb_q;
  logic            rx_ferr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      uart_q    <= StIdle;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      rx_stb_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_stb_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      unique case (uart_q)
        StIdle: begin
          if (line_prev_q && !line_q) begin
            uart_q <= StStart;
            tick_q <= '0;
          end
        end
        StStart: begin
          if (tick_q == HalfLast) begin
            tick_q <= '0;
            bit_q  <= '0;
            uart_q <= line_q ? StIdle : StData;
          end else begin
            tick_q <= tick_q + CW'(1);
          end
        end
        StData: begin
          if (tick_q == BitLast) begin
            tick_q  <= '0;
            shift_q <= {line_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) uart_q <= StStop;
          end else begin
            tick_q <= tick_q + CW'(1);
          end
        end
        StStop: begin
          if (tick_q == BitLast) begin
            // Back to idle at mid-stop so a back-to-back start edge is caught.
            uart_q    <= StIdle;
            tick_q    <= '0;
            rx_stb_q  <= line_q;
            rx_ferr_q <= !line_q;
            rx_byte_q <= shift_q;
          end else begin
            tick_q <= tick_q + CW'(1);
          end
        end
        default: uart_q <= StIdle;
      endcase
    end
  end

  function automatic logic [31:0] crc32c_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'h82F63B78) : (c >> 1);
    end
    return c;
  endfunction

  parse_st_e   parse_q;
  logic [1:0]  sof_q;
  logic [6:0]  pay_cnt_q;
  logic [1:0]  crc_idx_q;
  logic [31:0] crc_q;
  logic [31:0] crc_rx_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      parse_q     <= StHunt;
      sof_q       <= '0;
      pay_cnt_q   <= '0;
      crc_idx_q   <= '0;
      crc_q       <= '0;
      crc_rx_q    <= '0;
      o_dat       <= '0;
      o_valid     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      if (rx_ferr_q) begin
        if (parse_q != StHunt) begin
          o_frame_err <= 1'b1;
          if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end
        parse_q <= StHunt;
        sof_q   <= '0;
      end else if (rx_stb_q) begin
        unique case (parse_q)
          StHunt: begin
            if (rx_byte_q == {6'd0, sof_q}) begin
              if (sof_q == 2'd3) begin
                parse_q   <= StPayload;
                sof_q     <= '0;
                crc_q     <= 32'hFFFF_FFFF;
                pay_cnt_q <= '0;
              end else begin
                sof_q <= sof_q + 2'd1;
              end
            end else begin
              // A stray 0x00 can itself be the first SOF byte.
              sof_q <= (rx_byte_q == 8'h00) ? 2'd1 : 2'd0;
            end
          end
          StPayload: begin
            crc_q     <= crc32c_byte(crc_q, rx_byte_q);
            o_dat     <= rx_byte_q;
            o_valid   <= 1'b1;
            pay_cnt_q <= pay_cnt_q + 7'd1;
            if (pay_cnt_q == 7'd127) begin
              parse_q   <= StCrc;
              crc_idx_q <= '0;
            end
          end
          StCrc: begin
            crc_rx_q[{crc_idx_q, 3'b000} +: 8] <= rx_byte_q;
            crc_idx_q <= crc_idx_q + 2'd1;
            if (crc_idx_q == 2'd3) begin
              if ({rx_byte_q, crc_rx_q[23:0]} == crc_q) begin
                o_frame_ok <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
              end
              parse_q <= StHunt;
              sof_q   <= '0;
            end
          end
          default: parse_q <= StHunt;
        endcase
      end
    end
  end

  assign o_serial_rts_n = ~i_reset_n;

endmodule

// File: tb/tb_trng_rx.sv
// Scoreboard bench for trng_rx: stimulus pushes expected pulses, a monitor pops and compares.
module tb_trng_rx;

  localparam int unsigned Cpb     = 3;
  localparam int unsigned BitClks = Cpb + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       rts_n;
  logic [7:0] dat;
  logic       valid;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  trng_rx #(.CYCLES_PER_BIT(Cpb)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_serial_data  (line),
    .o_serial_rts_n (rts_n),
    .o_dat          (dat),
    .o_valid        (valid),
    .o_frame_ok     (frame_ok),
    .o_frame_err    (frame_err),
    .o_err_cnt      (err_cnt)
  );

  // kind: 0 = payload byte, 1 = frame ok, 2 = frame error
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_got;
  ev_t  mon_want;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_events = 0;
  int   exp_err = 0;
  int   evt_mark;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid || frame_ok || frame_err)) begin
      n_events++;
      check("one_pulse_per_cycle", 32'(valid) + 32'(frame_ok) + 32'(frame_err), 32'd1);
      mon_got.kind = valid ? 2'd0 : (frame_ok ? 2'd1 : 2'd2);
      mon_got.data = valid ? dat : 8'h00;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d data %h, expected none",
                 mon_got.kind, mon_got.data);
      end else begin
        mon_want = exp_q.pop_front();
        check("event", {22'd0, mon_got}, {22'd0, mon_want});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'h82F63B78) : (c >> 1);
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    line = v;
    cycles(BitClks);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    drive(stop_bit);
    line = 1'b1;
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
    if (kind == 2'd2 && exp_err != 255) exp_err++;
  endtask

  // Payload is 0x00..0x7F; flip_idx corrupts one payload bit, stop_idx sends a bad stop bit.
  task automatic send_frame(input int flip_idx, input int stop_idx);
    logic [31:0] crc;
    logic [7:0]  b;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 128; i++) crc = crc_step(crc, 8'(i));
    for (int k = 0; k < 4; k++) send_byte(8'(k), 1'b1);
    for (int i = 0; i < 128; i++) begin
      b = 8'(i);
      if (i == flip_idx) b = b ^ 8'h20;
      if (i == stop_idx) begin
        push_ev(2'd2, 8'h00);
        send_byte(b, 1'b0);
        drive(1'b1);
        return;
      end
      push_ev(2'd0, b);
      send_byte(b, 1'b1);
    end
    push_ev((flip_idx >= 0) ? 2'd2 : 2'd1, 8'h00);
    for (int j = 0; j < 4; j++) send_byte(crc[8*j +: 8], 1'b1);
    drive(1'b1);
    drive(1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) cycles(1);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] crc;
    string       s;

    rst_n = 1'b0;
    line  = 1'b1;
    cycles(3);
    check("reset_outputs", {12'd0, rts_n, valid, frame_ok, frame_err, dat, err_cnt},
          {12'd0, 1'b1, 3'b000, 8'h00, 8'h00});
    rst_n = 1'b1;
    cycles(2);
    check("rts_after_release", {31'd0, rts_n}, 32'd0);

    s = "123456789";
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) crc = crc_step(crc, s[i]);
    check("crc_model_check_string", crc, 32'h1CF9_6D7C);

    send_frame(-1, -1);
    wait_drain("drain_good_frame");
    check("err_cnt_good", {24'd0, err_cnt}, 32'd0);

    send_frame(5, -1);
    wait_drain("drain_crc_error");
    check("err_cnt_crc_error", {24'd0, err_cnt}, 32'd1);

    // Stream is 00 00 01 05 00 01 02 03 <payload> <crc>.
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h05, 1'b1);
    send_frame(-1, -1);
    wait_drain("drain_garbage_then_good");
    check("err_cnt_garbage", {24'd0, err_cnt}, 32'd1);

    send_frame(-1, 10);
    send_frame(-1, -1);
    wait_drain("drain_stop_error");
    check("err_cnt_stop_error", {24'd0, err_cnt}, 32'(exp_err));

    evt_mark = n_events;
    line = 1'b0;
    cycles(2);
    line = 1'b1;
    cycles(5 * BitClks);
    check("glitch_no_byte", 32'(n_events), 32'(evt_mark));

    // Reset mid-way through payload byte 60.
    for (int k = 0; k < 4; k++) send_byte(8'(k), 1'b1);
    for (int i = 0; i < 60; i++) begin
      push_ev(2'd0, 8'(i));
      send_byte(8'(i), 1'b1);
    end
    drive(1'b0);
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_frame_reset_outputs",
          {12'd0, rts_n, valid, frame_ok, frame_err, dat, err_cnt},
          {12'd0, 1'b1, 3'b000, 8'h00, 8'h00});
    check("queue_empty_at_reset", 32'(exp_q.size()), 32'd0);
    exp_err  = 0;
    evt_mark = n_events;
    line     = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    check("rts_after_second_release", {31'd0, rts_n}, 32'd0);
    cycles(3 * BitClks);
    line = 1'b1;
    cycles(3 * BitClks);
    check("low_at_release_no_byte", 32'(n_events), 32'(evt_mark));

    send_frame(-1, -1);
    wait_drain("drain_after_reset");
    check("err_cnt_after_reset", {24'd0, err_cnt}, 32'd0);

    for (int f = 0; f < 300; f++) begin
      for (int k = 0; k < 4; k++) send_byte(8'(k), 1'b1);
      push_ev(2'd2, 8'h00);
      send_byte(8'h00, 1'b0);
      drive(1'b1);
      if (f == 99) check("err_cnt_100", {24'd0, err_cnt}, 32'd100);
    end
    wait_drain("drain_saturation");
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'h0000_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
